// File: rtl/gcm_pkg.sv
// Shared definitions for the GCM counter-block generator: controller states
// and the default block geometry (128-bit blocks, 32-bit incrementing field).
package gcm_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } gcm_state_e;

    localparam int GCM_DATA_WIDTH = 128;
    localparam int GCM_S          = 32;

endpackage

// File: rtl/gcm_inc_lane.sv
// One counter lane: applies inc_S to a counter block 'offset' times, i.e. adds
// the offset to the right-most S bits modulo 2^S and leaves the upper bits alone.
// Purely combinational. A degenerate field width (S == 0 or wider than the
// block) passes the block through unchanged.
module gcm_inc_lane #(
    parameter int DATA_WIDTH = 128,
    parameter int S          = 32,
    parameter int OFF_WIDTH  = 32
) (
    input  logic [DATA_WIDTH-1:0] block,
    input  logic [OFF_WIDTH-1:0]  offset,
    output logic [DATA_WIDTH-1:0] result
);

    generate
        if (S == 0 || S > DATA_WIDTH) begin : g_pass
            logic unused_offset;
            assign unused_offset = ^offset;
            assign result        = block;
        end else if (S == DATA_WIDTH) begin : g_full
            assign result = block + DATA_WIDTH'(offset);
        end else begin : g_part
            assign result = {block[DATA_WIDTH-1:S], block[S-1:0] + S'(offset)};
        end
    endgenerate

endmodule

// File: rtl/gcm_ctr_gen.sv
// GCM counter-block generator. A job (initial counter block + block count) is
// accepted in IDLE and streamed out as beats of LANES counter blocks over a
// valid/ready handshake. Jobs that would make the S-bit field wrap back onto
// a block already produced are refused with a wrap_err pulse.
module gcm_ctr_gen
    import gcm_pkg::*;
#(
    parameter int DATA_WIDTH = GCM_DATA_WIDTH,
    parameter int S          = GCM_S,
    parameter int LANES      = 1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [DATA_WIDTH-1:0]       icb,
    input  logic [CNT_WIDTH-1:0]        num_blocks,
    output logic                        cb_valid,
    input  logic                        cb_ready,
    output logic [LANES*DATA_WIDTH-1:0] cb_data,
    output logic [LANES-1:0]            cb_mask,
    output logic                        cb_last,
    output logic                        busy,
    output logic                        done,
    output logic                        wrap_err
);

    // Largest legal job is 2^S blocks; only a count input wider than S can exceed it.
    localparam bit              CAN_WRAP = (S < CNT_WIDTH);
    localparam logic [CNT_WIDTH:0] LIMIT = {{CNT_WIDTH{1'b0}}, 1'b1} << (CAN_WRAP ? S : 0);

    gcm_state_e state, state_nxt;

    logic [DATA_WIDTH-1:0] icb_r;
    logic [CNT_WIDTH-1:0]  num_r;
    logic [CNT_WIDTH-1:0]  next_idx;

    logic [DATA_WIDTH-1:0]       base_blk;
    logic [CNT_WIDTH-1:0]        base_idx;
    logic [CNT_WIDTH-1:0]        total;
    logic [CNT_WIDTH-1:0]        remaining;
    logic [DATA_WIDTH-1:0]       lane_blk [LANES];
    logic [LANES*DATA_WIDTH-1:0] beat_data;
    logic [LANES-1:0]            beat_mask;
    logic                        beat_last;
    logic                        too_big;
    logic                        beat_taken;

    assign too_big    = CAN_WRAP && ({1'b0, num_blocks} > LIMIT);
    assign beat_taken = cb_valid && cb_ready;

    // In IDLE the first beat is built straight from the inputs so it can be
    // registered on the accepting edge; afterwards the latched job is used.
    always_comb begin
        base_blk = icb_r;
        base_idx = next_idx;
        total    = num_r;
        if (state == IDLE) begin
            base_blk = icb;
            base_idx = '0;
            total    = num_blocks;
        end
        remaining = total - base_idx;
    end

    generate
        for (genvar i = 0; i < LANES; i++) begin : g_lane
            gcm_inc_lane #(
                .DATA_WIDTH (DATA_WIDTH),
                .S          (S),
                .OFF_WIDTH  (CNT_WIDTH)
            ) u_lane (
                .block  (base_blk),
                .offset (base_idx + CNT_WIDTH'(i)),
                .result (lane_blk[i])
            );
        end
    endgenerate

    // Assemble the candidate beat: lanes past the end of the job are masked and zeroed.
    always_comb begin
        beat_data = '0;
        beat_mask = '0;
        beat_last = (remaining <= CNT_WIDTH'(LANES));
        for (int i = 0; i < LANES; i++) begin
            beat_mask[i] = (remaining > CNT_WIDTH'(i));
            if (beat_mask[i]) begin
                beat_data[i*DATA_WIDTH +: DATA_WIDTH] = lane_blk[i];
            end
        end
    end

    // Controller state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: empty jobs go straight to FIN, oversize jobs stay in IDLE.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    if (num_blocks == '0) begin
                        state_nxt = FIN;
                    end else if (!too_big) begin
                        state_nxt = RUN;
                    end
                end
            end
            RUN: begin
                if (beat_taken && cb_last) begin
                    state_nxt = FIN;
                end
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs and job bookkeeping; a beat is only replaced once it is taken.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            icb_r    <= '0;
            num_r    <= '0;
            next_idx <= '0;
            cb_valid <= 1'b0;
            cb_data  <= '0;
            cb_mask  <= '0;
            cb_last  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            wrap_err <= 1'b0;
        end else begin
            busy     <= (state_nxt != IDLE);
            done     <= (state_nxt == FIN);
            wrap_err <= (state == IDLE) && start && too_big;
            case (state)
                IDLE: begin
                    if (state_nxt == RUN) begin
                        icb_r    <= icb;
                        num_r    <= num_blocks;
                        next_idx <= CNT_WIDTH'(LANES);
                        cb_valid <= 1'b1;
                        cb_data  <= beat_data;
                        cb_mask  <= beat_mask;
                        cb_last  <= beat_last;
                    end
                end
                RUN: begin
                    if (beat_taken) begin
                        if (cb_last) begin
                            cb_valid <= 1'b0;
                            cb_data  <= '0;
                            cb_mask  <= '0;
                            cb_last  <= 1'b0;
                        end else begin
                            next_idx <= next_idx + CNT_WIDTH'(LANES);
                            cb_data  <= beat_data;
                            cb_mask  <= beat_mask;
                            cb_last  <= beat_last;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gcm_ctr_gen.sv
// Bench for gcm_ctr_gen. Two instances: a narrow one (8-bit blocks, S=5, one
// lane, 8-bit count) and a default-width one with four lanes. Expected beats
// are queued when a job is issued; a monitor per instance pops and compares
// every handshaken beat.
module tb_gcm_ctr_gen;

    typedef struct packed {
        logic         last;
        logic [3:0]   mask;
        logic [511:0] data;
    } beat_t;

    logic clk = 1'b0;
    logic rst;

    // Narrow instance signals.
    logic         start_a;
    logic [7:0]   icb_a;
    logic [7:0]   num_a;
    logic         ready_a;
    logic         valid_a;
    logic [7:0]   data_a;
    logic [0:0]   mask_a;
    logic         last_a, busy_a, done_a, werr_a;

    // Wide instance signals.
    logic         start_b;
    logic [127:0] icb_b;
    logic [31:0]  num_b;
    logic         ready_b;
    logic         valid_b;
    logic [511:0] data_b;
    logic [3:0]   mask_b;
    logic         last_b, busy_b, done_b, werr_b;

    int    n_checks = 0;
    int    n_fail   = 0;
    beat_t exp_a[$];
    beat_t exp_b[$];
    beat_t mon_a;
    beat_t mon_b;

    localparam logic [95:0] UPPER_B = 96'h0123_4567_89AB_CDEF_0011_2233;

    always #5 clk = ~clk;

    gcm_ctr_gen #(
        .DATA_WIDTH (8),
        .S          (5),
        .LANES      (1),
        .CNT_WIDTH  (8)
    ) dut_a (
        .clk        (clk),
        .rst        (rst),
        .start      (start_a),
        .icb        (icb_a),
        .num_blocks (num_a),
        .cb_valid   (valid_a),
        .cb_ready   (ready_a),
        .cb_data    (data_a),
        .cb_mask    (mask_a),
        .cb_last    (last_a),
        .busy       (busy_a),
        .done       (done_a),
        .wrap_err   (werr_a)
    );

    gcm_ctr_gen #(
        .LANES      (4)
    ) dut_b (
        .clk        (clk),
        .rst        (rst),
        .start      (start_b),
        .icb        (icb_b),
        .num_blocks (num_b),
        .cb_valid   (valid_b),
        .cb_ready   (ready_b),
        .cb_data    (data_b),
        .cb_mask    (mask_b),
        .cb_last    (last_b),
        .busy       (busy_b),
        .done       (done_b),
        .wrap_err   (werr_b)
    );

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic pushA(input logic [7:0] d, input logic l);
        exp_a.push_back('{l, 4'b0001, 512'(d)});
    endtask

    task automatic applyStimulusA(input logic [7:0] icb, input logic [7:0] n);
        @(posedge clk); #1;
        start_a = 1'b1;
        icb_a   = icb;
        num_a   = n;
        @(posedge clk); #1;
        start_a = 1'b0;
    endtask

    task automatic applyStimulusB(input logic [127:0] icb, input logic [31:0] n);
        @(posedge clk); #1;
        start_b = 1'b1;
        icb_b   = icb;
        num_b   = n;
        @(posedge clk); #1;
        start_b = 1'b0;
    endtask

    // Waits (bounded) for the done pulse, then confirms the job fully drained and done drops.
    task automatic waitDoneA(input string name, input int bound);
        bit seen = 1'b0;
        for (int c = 0; c < bound && !seen; c++) begin
            @(negedge clk);
            if (done_a) seen = 1'b1;
        end
        checkOutput({name, "_done_seen"}, 512'(seen), 512'(1));
        if (seen) begin
            checkOutput({name, "_drained"}, 512'(exp_a.size()), 512'(0));
            checkOutput({name, "_busy_in_fin"}, 512'(busy_a), 512'(1));
            @(negedge clk);
            checkOutput({name, "_done_one_cycle"}, 512'({done_a, busy_a}), 512'(0));
        end
    endtask

    task automatic waitDoneB(input string name, input int bound);
        bit seen = 1'b0;
        for (int c = 0; c < bound && !seen; c++) begin
            @(negedge clk);
            if (done_b) seen = 1'b1;
        end
        checkOutput({name, "_done_seen"}, 512'(seen), 512'(1));
        if (seen) begin
            checkOutput({name, "_drained"}, 512'(exp_b.size()), 512'(0));
            @(negedge clk);
            checkOutput({name, "_done_one_cycle"}, 512'(done_b), 512'(0));
        end
    endtask

    // Narrow-instance monitor: every taken beat must match the head of the queue.
    always @(negedge clk) begin
        if (rst && valid_a && ready_a) begin
            if (exp_a.size() == 0) begin
                checkOutput("a_unexpected_beat", 512'(data_a), 512'(0));
            end else begin
                mon_a = exp_a.pop_front();
                checkOutput("a_data", 512'(data_a), mon_a.data);
                checkOutput("a_mask", 512'(mask_a), 512'(mon_a.mask[0]));
                checkOutput("a_last", 512'(last_a), 512'(mon_a.last));
            end
        end
    end

    // Wide-instance monitor.
    always @(negedge clk) begin
        if (rst && valid_b && ready_b) begin
            if (exp_b.size() == 0) begin
                checkOutput("b_unexpected_beat", data_b, 512'(0));
            end else begin
                mon_b = exp_b.pop_front();
                checkOutput("b_data", data_b, mon_b.data);
                checkOutput("b_mask", 512'(mask_b), 512'(mon_b.mask));
                checkOutput("b_last", 512'(last_b), 512'(mon_b.last));
            end
        end
    end

    // Watchdog so a stuck handshake can never hang the run.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached before test end");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst     = 1'b0;
        start_a = 1'b0; icb_a = '0; num_a = '0; ready_a = 1'b1;
        start_b = 1'b0; icb_b = '0; num_b = '0; ready_b = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("a_reset_state", 512'({valid_a, mask_a, last_a, busy_a, done_a, werr_a, data_a}), 512'(0));
        checkOutput("b_reset_state", {data_b[511:9], valid_b, mask_b, last_b, busy_b, done_b, werr_b}, 512'(0));
        @(posedge clk); #1;
        rst = 1'b1;

        // Basic run: E3, E4, E5.
        pushA(8'hE3, 1'b0); pushA(8'hE4, 1'b0); pushA(8'hE5, 1'b1);
        applyStimulusA(8'hE3, 8'd3);
        checkOutput("a_first_beat_latency", 512'({valid_a, data_a}), 512'({1'b1, 8'hE3}));
        waitDoneA("a_basic", 20);

        // Field wrap keeps the upper three bits.
        pushA(8'hFE, 1'b0); pushA(8'hFF, 1'b0); pushA(8'hE0, 1'b1);
        applyStimulusA(8'hFE, 8'd3);
        waitDoneA("a_wrap_field", 20);

        // Back-pressure mid-job: beat 00 must hold for three stalled cycles.
        pushA(8'h1F, 1'b0); pushA(8'h00, 1'b0); pushA(8'h01, 1'b0); pushA(8'h02, 1'b1);
        applyStimulusA(8'h1F, 8'd4);
        @(posedge clk); #1;
        ready_a = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("a_stall_hold", 512'({valid_a, last_a, mask_a, data_a}), 512'({1'b1, 1'b0, 1'b1, 8'h00}));
        end
        @(posedge clk); #1;
        ready_a = 1'b1;
        waitDoneA("a_stall", 20);

        // Oversize job: 33 > 2^5.
        applyStimulusA(8'h10, 8'd33);
        @(negedge clk);
        checkOutput("a_wrap_err_pulse", 512'({werr_a, valid_a, busy_a}), 512'({1'b1, 1'b0, 1'b0}));
        @(negedge clk);
        checkOutput("a_wrap_err_clear", 512'({werr_a, valid_a, busy_a}), 512'(0));

        // Empty job: straight to completion.
        applyStimulusA(8'h10, 8'd0);
        @(negedge clk);
        checkOutput("a_empty_done", 512'({done_a, busy_a, valid_a}), 512'({1'b1, 1'b1, 1'b0}));
        @(negedge clk);
        checkOutput("a_empty_after", 512'({done_a, busy_a, valid_a}), 512'(0));

        // Reset in the middle of a job after two beats were taken.
        for (int k = 0; k < 8; k++) pushA(8'h40 + 8'(k), (k == 7));
        applyStimulusA(8'h40, 8'd8);
        @(posedge clk);
        @(posedge clk); #3;
        rst = 1'b0;
        #1;
        checkOutput("a_async_reset", 512'({valid_a, mask_a, last_a, busy_a, done_a, werr_a, data_a}), 512'(0));
        checkOutput("a_reset_after_two", 512'(exp_a.size()), 512'(6));
        exp_a.delete();
        @(posedge clk); #1;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checkOutput("a_no_done_after_abort", 512'({done_a, valid_a, busy_a}), 512'(0));
        end
        pushA(8'hE3, 1'b0); pushA(8'hE4, 1'b0); pushA(8'hE5, 1'b1);
        applyStimulusA(8'hE3, 8'd3);
        waitDoneA("a_after_reset", 20);

        // Four lanes, six blocks crossing the 32-bit field wrap.
        exp_b.push_back('{1'b0, 4'b1111,
            {UPPER_B, 32'h0000_0001, UPPER_B, 32'h0000_0000, UPPER_B, 32'hFFFF_FFFF, UPPER_B, 32'hFFFF_FFFE}});
        exp_b.push_back('{1'b1, 4'b0011,
            {128'h0, 128'h0, UPPER_B, 32'h0000_0003, UPPER_B, 32'h0000_0002}});
        applyStimulusB({UPPER_B, 32'hFFFF_FFFE}, 32'd6);
        waitDoneB("b_lanes", 20);

        checkOutput("a_queue_empty_end", 512'(exp_a.size()), 512'(0));
        checkOutput("b_queue_empty_end", 512'(exp_b.size()), 512'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
